// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the write responder and the write master.
package i2c_pkg;

   localparam int unsigned I2C_BYTE_W   = 8;
   localparam int unsigned I2C_BITCNT_W = 3;
   localparam logic [7:0]  I2C_DEV_ADDR = 8'h34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_SUB,
      ST_ACK_S,
      ST_DATA,
      ST_ACK_D,
      ST_IGNORE
   } i2c_state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop sync, stability filter, edge and START/STOP detect.
module i2c_line_cond #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_f_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

   // Bit 0 carries SCL, bit 1 carries SDA.
   logic [1:0]       meta_q;
   logic [1:0]       sync_q;
   logic [1:0]       filt_q;
   logic [1:0]       prev_q;
   logic [CNT_W-1:0] cnt_q [2];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q   <= '1;
         sync_q   <= '1;
         filt_q   <= '1;
         prev_q   <= '1;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         meta_q <= {sda_i, scl_i};
         sync_q <= meta_q;
         prev_q <= filt_q;
         // A new level is adopted only after FILT_LEN consecutive disagreeing samples.
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
               filt_q[i] <= sync_q[i];
               cnt_q[i]  <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign sda_f_o    = filt_q[1];
   assign scl_rise_o = filt_q[0] & ~prev_q[0];
   assign scl_fall_o = ~filt_q[0] & prev_q[0];
   assign start_o    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
   assign stop_o     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

endmodule

// File: rtl/i2c_write_responder.sv
// I2C slave accepting [dev addr+W][sub addr][data] frames and emitting one register write each.
module i2c_write_responder
   import i2c_pkg::*;
#(
   parameter logic [7:0]  DEV_ADDR  = I2C_DEV_ADDR,
   parameter int unsigned FILT_LEN  = 3,
   parameter int unsigned TO_CYCLES = 4095
) (
   input  logic       CLOCK,
   input  logic       iRST_N,
   input  logic       I2C_SCLK,
   inout  logic       I2C_SDAT,
   output logic [7:0] REG_ADDR,
   output logic [7:0] REG_DATA,
   output logic       REG_WE,
   output logic       BUSY,
   output logic       ERR
);

   localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);

   logic sda_f;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_line_cond (
      .clk_i      (CLOCK),
      .rst_i      (iRST_N),
      .scl_i      (I2C_SCLK),
      .sda_i      (I2C_SDAT),
      .sda_f_o    (sda_f),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   i2c_state_e              state_q;
   logic [I2C_BYTE_W-1:0]   shift_q;
   logic [I2C_BITCNT_W-1:0] bitcnt_q;
   logic                    byte_done_q;
   logic [I2C_BYTE_W-1:0]   sub_q;
   logic                    sda_oe_q;
   logic [TO_W-1:0]         to_q;

   logic scl_edge;
   logic timeout;

   assign scl_edge = scl_rise | scl_fall;
   assign timeout  = (state_q != ST_IDLE) && !scl_edge && (to_q == TO_W'(TO_CYCLES - 1));

   // Open-drain: only ever pull low.
   assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

   always_ff @(posedge CLOCK or posedge iRST_N) begin
      if (iRST_N) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bitcnt_q    <= '0;
         byte_done_q <= 1'b0;
         sub_q       <= '0;
         sda_oe_q    <= 1'b0;
         to_q        <= '0;
         REG_ADDR    <= '0;
         REG_DATA    <= '0;
         REG_WE      <= 1'b0;
         BUSY        <= 1'b0;
         ERR         <= 1'b0;
      end else begin
         REG_WE <= 1'b0;
         ERR    <= 1'b0;

         if (scl_edge || state_q == ST_IDLE) begin
            to_q <= '0;
         end else if (!timeout) begin
            to_q <= to_q + 1'b1;
         end

         // Bus conditions override the byte/ACK sequencing in every state.
         if (timeout) begin
            state_q     <= ST_IDLE;
            sda_oe_q    <= 1'b0;
            BUSY        <= 1'b0;
            ERR         <= 1'b1;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
         end else if (start_det) begin
            ERR         <= BUSY && (state_q != ST_IGNORE);
            state_q     <= ST_ADDR;
            sda_oe_q    <= 1'b0;
            BUSY        <= 1'b0;
            sub_q       <= '0;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
         end else if (stop_det) begin
            ERR         <= state_q inside {ST_ADDR, ST_ACK_A, ST_SUB, ST_ACK_S, ST_DATA};
            state_q     <= ST_IDLE;
            sda_oe_q    <= 1'b0;
            BUSY        <= 1'b0;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
         end else begin
            case (state_q)
               ST_ADDR, ST_SUB, ST_DATA: begin
                  if (scl_rise) begin
                     shift_q  <= {shift_q[I2C_BYTE_W-2:0], sda_f};
                     bitcnt_q <= bitcnt_q + 1'b1;
                     if (bitcnt_q == '1) byte_done_q <= 1'b1;
                  end else if (scl_fall && byte_done_q) begin
                     byte_done_q <= 1'b0;
                     if (state_q == ST_ADDR) begin
                        if (shift_q == DEV_ADDR) begin
                           state_q  <= ST_ACK_A;
                           sda_oe_q <= 1'b1;
                           BUSY     <= 1'b1;
                        end else begin
                           state_q <= ST_IGNORE;
                        end
                     end else if (state_q == ST_SUB) begin
                        state_q  <= ST_ACK_S;
                        sda_oe_q <= 1'b1;
                        sub_q    <= shift_q;
                     end else begin
                        state_q  <= ST_ACK_D;
                        sda_oe_q <= 1'b1;
                        REG_ADDR <= sub_q;
                        REG_DATA <= shift_q;
                        REG_WE   <= 1'b1;
                     end
                  end
               end
               ST_ACK_A: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= ST_SUB;
                  end
               end
               ST_ACK_S: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= ST_DATA;
                  end
               end
               ST_ACK_D: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= ST_IGNORE;
                  end
               end
               ST_IDLE, ST_IGNORE: begin
                  sda_oe_q <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_write_responder.sv
// Randomized bench for i2c_write_responder: bit-banged master, frame-level model, write scoreboard.
module tb_i2c_write_responder;

   localparam logic [7:0]  DEV = 8'h34;
   localparam int unsigned TO  = 4095;

   logic       CLOCK = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_drv_low;
   wire        sda_bus;
   logic [7:0] REG_ADDR;
   logic [7:0] REG_DATA;
   logic       REG_WE;
   logic       BUSY;
   logic       ERR;

   pullup (sda_bus);
   assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;

   always #5 CLOCK = ~CLOCK;

   i2c_write_responder #(.DEV_ADDR(DEV), .FILT_LEN(3), .TO_CYCLES(TO)) dut (
      .CLOCK    (CLOCK),
      .iRST_N   (rst),
      .I2C_SCLK (scl),
      .I2C_SDAT (sda_bus),
      .REG_ADDR (REG_ADDR),
      .REG_DATA (REG_DATA),
      .REG_WE   (REG_WE),
      .BUSY     (BUSY),
      .ERR      (ERR)
   );

   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] exp_q[$];
   int          err_seen = 0;
   int          exp_err = 0;
   bit          open_incomplete = 0;
   bit          busy_seen = 0;
   logic [7:0]  exp_addr = '0;
   logic [7:0]  exp_data = '0;
   logic        prev_we = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   // Monitor: pops the scoreboard on every write strobe, counts ERR pulses.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge CLOCK);
         if (!rst) begin
            if (ERR) err_seen++;
            if (BUSY) busy_seen = 1;
            if (REG_WE) begin
               check("we_width", {31'd0, prev_we}, 0);
               check("write_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("we_addr", REG_ADDR, e[15:8]);
                  check("we_data", REG_DATA, e[7:0]);
               end
            end
            prev_we = REG_WE;
         end else begin
            prev_we = 1'b0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

   task automatic i2c_start();
      sda_drv_low = 1'b1;
      clk_n(6);
      scl = 1'b0;
      clk_n(2);
   endtask

   task automatic i2c_restart();
      clk_n(4);
      sda_drv_low = 1'b0;
      clk_n(12);
      scl = 1'b1;
      clk_n(8);
      exp_err += int'(open_incomplete);
      open_incomplete = 0;
      sda_drv_low = 1'b1;
      clk_n(8);
      scl = 1'b0;
      clk_n(2);
   endtask

   task automatic i2c_stop();
      clk_n(4);
      sda_drv_low = 1'b1;
      clk_n(4);
      scl = 1'b1;
      clk_n(6);
      sda_drv_low = 1'b0;
      exp_err += int'(open_incomplete);
      open_incomplete = 0;
      clk_n(10);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      clk_n(4);
      sda_drv_low = ~b;
      clk_n(4);
      scl = 1'b1;
      clk_n(4);
      if (glitch) begin
         scl = 1'b0;
         clk_n(1);
         scl = 1'b1;
         clk_n(3);
      end else begin
         clk_n(4);
      end
      scl = 1'b0;
   endtask

   task automatic read_ack(output logic a);
      clk_n(4);
      sda_drv_low = 1'b0;
      clk_n(4);
      scl = 1'b1;
      clk_n(4);
      a = sda_bus;
      clk_n(4);
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gbit, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(b[i], i == gbit);
      read_ack(a);
   endtask

   // Frame-level model: only a first byte equal to DEV is addressed; bytes 0..2 of an
   // addressed frame are ACKed, everything else NACKed; three bytes commit one write.
   task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int nbytes, input bit restart,
                        input int gbyte, input int gbit);
      logic [7:0] bytes [4];
      logic       a;
      bit         accept;
      bytes  = '{b0, b1, b2, b3};
      accept = (b0 == DEV);
      if (accept && nbytes >= 3) exp_q.push_back({b1, b2});
      if (restart) i2c_restart();
      else i2c_start();
      for (int k = 0; k < nbytes; k++) begin
         send_byte(bytes[k], (k == gbyte) ? gbit : -1, a);
         check($sformatf("ack_byte%0d", k), {31'd0, a}, (accept && k < 3) ? 0 : 1);
      end
      if (accept && nbytes >= 3) begin
         exp_addr = b1;
         exp_data = b2;
      end
      open_incomplete = accept && (nbytes < 3);
   endtask

   task automatic checkpoint();
      clk_n(4);
      check("err_count", err_seen, exp_err);
      check("reg_addr", REG_ADDR, exp_addr);
      check("reg_data", REG_DATA, exp_data);
      check("writes_done", exp_q.size(), 0);
   endtask

   initial begin
      logic a;
      bit   chain;
      rst = 1'b1;
      scl = 1'b1;
      sda_drv_low = 1'b0;
      clk_n(3);
      check("rst_reg_addr", REG_ADDR, 0);
      check("rst_reg_data", REG_DATA, 0);
      check("rst_reg_we", {31'd0, REG_WE}, 0);
      check("rst_busy", {31'd0, BUSY}, 0);
      check("rst_err", {31'd0, ERR}, 0);
      check("rst_sda", {31'd0, sda_bus}, 1);
      rst = 1'b0;
      clk_n(10);

      frame(8'h34, 8'h12, 8'hAB, 8'h00, 3, 0, -1, -1);
      i2c_stop();
      checkpoint();

      busy_seen = 0;
      frame(8'h36, 8'h12, 8'hAB, 8'h00, 3, 0, -1, -1);
      i2c_stop();
      checkpoint();
      check("busy_on_nack", {31'd0, busy_seen}, 0);

      frame(8'h34, 8'h05, 8'h00, 8'h00, 2, 0, -1, -1);
      i2c_stop();
      checkpoint();

      frame(8'h34, 8'h05, 8'h00, 8'h00, 2, 0, -1, -1);
      frame(8'h34, 8'h07, 8'h5A, 8'h00, 3, 1, -1, -1);
      i2c_stop();
      checkpoint();

      frame(8'h34, 8'h3C, 8'hC3, 8'h00, 3, 0, 2, 4);
      i2c_stop();
      checkpoint();

      // SCL stalls high in the middle of the data byte.
      i2c_start();
      send_byte(8'h34, -1, a);
      check("to_ack_addr", {31'd0, a}, 0);
      send_byte(8'h55, -1, a);
      check("to_ack_sub", {31'd0, a}, 0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
      clk_n(4);
      scl = 1'b1;
      clk_n(TO + 40);
      exp_err++;
      check("to_busy", {31'd0, BUSY}, 0);
      check("to_sda", {31'd0, sda_bus}, 1);
      checkpoint();
      frame(8'h34, 8'h21, 8'h9E, 8'h00, 3, 0, -1, -1);
      i2c_stop();
      checkpoint();

      // Reset asserted while the responder is holding the sub-address ACK.
      i2c_start();
      send_byte(8'h34, -1, a);
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h66 >> i), 0);
      clk_n(4);
      sda_drv_low = 1'b0;
      clk_n(4);
      scl = 1'b1;
      clk_n(2);
      check("acks_drive", {31'd0, sda_bus}, 0);
      rst = 1'b1;
      #1;
      check("rst_async_sda", {31'd0, sda_bus}, 1);
      clk_n(2);
      check("rst_mid_busy", {31'd0, BUSY}, 0);
      check("rst_mid_addr", REG_ADDR, 0);
      exp_addr = '0;
      exp_data = '0;
      open_incomplete = 0;
      rst = 1'b0;
      clk_n(10);

      chain = 0;
      for (int n = 0; n < 16; n++) begin
         logic [7:0] b0;
         int         nb;
         int         gb;
         b0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV;
         nb = $urandom_range(1, 4);
         gb = $urandom_range(0, 8);
         frame(b0, 8'($urandom), 8'($urandom), 8'($urandom), nb, chain,
               $urandom_range(0, 3), (gb == 8) ? -1 : gb);
         chain = ($urandom_range(0, 2) == 0);
         if (!chain) begin
            i2c_stop();
            checkpoint();
         end
      end
      if (chain) i2c_stop();
      checkpoint();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
